// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, LEGv8 opcode-field values and the
// issued-operation payload type.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    // 4-bit ALU opcodes
    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_CBZ = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // LEGv8 opcode fields, instr[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // instr[31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    // instr[31:23]
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    // instr[31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [ALU_W-1:0] in_one;
        logic [ALU_W-1:0] in_two;
        logic             illegal;
    } payload_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational LEGv8 decoder: maps an instruction word and its two register
// values onto the ALU payload (opcode, operands, illegal flag).
// Ports: instr, rnData, rmData in; payload out.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]      instr,
    input  logic [ALU_W-1:0] rnData,
    input  logic [ALU_W-1:0] rmData,
    output payload_t         payload
);

    always_comb begin
        payload = '{opcode: ALU_NOP, in_one: '0, in_two: '0, illegal: 1'b0};
        unique case (1'b1)
            instr[31:21] == OP_ADD: payload = '{ALU_ADD, rnData, rmData, 1'b0};
            instr[31:21] == OP_SUB: payload = '{ALU_SUB, rnData, rmData, 1'b0};
            instr[31:21] == OP_AND: payload = '{ALU_AND, rnData, rmData, 1'b0};
            instr[31:21] == OP_ORR: payload = '{ALU_OR,  rnData, rmData, 1'b0};
            instr[31:21] == OP_EOR: payload = '{ALU_XOR, rnData, rmData, 1'b0};
            (instr[31:21] == OP_LDUR) || (instr[31:21] == OP_STUR):
                payload = '{ALU_ADD, rnData, {{(ALU_W-9){instr[20]}}, instr[20:12]}, 1'b0};
            instr[31:22] == OP_ADDI:
                payload = '{ALU_ADD, rnData, {{(ALU_W-12){1'b0}}, instr[21:10]}, 1'b0};
            instr[31:22] == OP_SUBI:
                payload = '{ALU_SUB, rnData, {{(ALU_W-12){1'b0}}, instr[21:10]}, 1'b0};
            instr[31:23] == OP_MOVZ:
                // hw field ignored
                payload = '{ALU_MOV, {{(ALU_W-16){1'b0}}, instr[20:5]}, '0, 1'b0};
            instr[31:24] == OP_CBZ:
                // Rt arrives on the Rm read port
                payload = '{ALU_CBZ, rmData, '0, 1'b0};
            default: payload.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU. Accepts instruction + register
// operands over valid/ready, decodes, and presents the registered payload
// with a one-entry skid so instrReady never depends on opReady.
// Ports: clock, resetN; instrValid/instrReady/instr/rnData/rmData in-side;
// opValid/opReady/opcode/inOne/inTwo/illegal out-side; issueCount.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              instrValid,
    output logic              instrReady,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rnData,
    input  logic [DATA_W-1:0] rmData,
    output logic              opValid,
    input  logic              opReady,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] inOne,
    output logic [DATA_W-1:0] inTwo,
    output logic              illegal,
    output logic [CNT_W-1:0]  issueCount
);

    payload_t dec_pl;
    payload_t out_q, out_d;
    payload_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_full_q, skid_full_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic     accept, issue;

    alu_decode u_decode (
        .instr   (instr),
        .rnData  (rnData),
        .rmData  (rmData),
        .payload (dec_pl)
    );

    assign accept = instrValid & ~skid_full_q;
    assign issue  = out_valid_q & opReady;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        count_d     = issue ? count_q + 1'b1 : count_q;
        if (issue && skid_full_q) begin
            // accept cannot coincide here: instrReady is low while skid is full
            out_d       = skid_q;
            skid_full_d = 1'b0;
        end else begin
            if (issue) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (!out_valid_q || issue) begin
                    out_d       = dec_pl;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d      = dec_pl;
                    skid_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            count_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            count_q     <= count_d;
        end
    end

    assign instrReady = ~skid_full_q;
    assign opValid    = out_valid_q;
    assign opcode     = out_q.opcode;
    assign inOne      = out_q.in_one;
    assign inTwo      = out_q.in_two;
    assign illegal    = out_q.illegal;
    assign issueCount = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted instructions push the
// reference-model result; a monitor pops and compares on every issue.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] one;
        logic [31:0] two;
        logic        ill;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        instrValid = 1'b0;
    logic        instrReady;
    logic [31:0] instr = '0;
    logic [31:0] rnData = '0;
    logic [31:0] rmData = '0;
    logic        opValid;
    logic        opReady = 1'b0;
    logic [3:0]  opcode;
    logic [31:0] inOne;
    logic [31:0] inTwo;
    logic        illegal;
    logic [15:0] issueCount;

    exp_t        exp_q[$];
    logic [15:0] exp_count = '0;
    int          n_cmp = 0;
    int          n_fail = 0;

    alu_issue_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instr      (instr),
        .rnData     (rnData),
        .rmData     (rmData),
        .opValid    (opValid),
        .opReady    (opReady),
        .opcode     (opcode),
        .inOne      (inOne),
        .inTwo      (inTwo),
        .illegal    (illegal),
        .issueCount (issueCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model straight from the decode table.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] rn,
                                   input logic [31:0] rm);
        int unsigned f11, f10, f9, f8;
        int          imm9;
        exp_t        e;
        f11  = w >> 21;
        f10  = w >> 22;
        f9   = w >> 23;
        f8   = w >> 24;
        imm9 = int'((w >> 12) & 32'h1FF);
        if (imm9 >= 256) imm9 = imm9 - 512;
        e = '{4'd0, 32'd0, 32'd0, 1'b1};
        if (f11 == 'h458)                     e = '{4'd2,  rn, rm, 1'b0};
        else if (f11 == 'h658)                e = '{4'd10, rn, rm, 1'b0};
        else if (f11 == 'h450)                e = '{4'd6,  rn, rm, 1'b0};
        else if (f11 == 'h550)                e = '{4'd4,  rn, rm, 1'b0};
        else if (f11 == 'h650)                e = '{4'd9,  rn, rm, 1'b0};
        else if (f11 == 'h7C2 || f11 == 'h7C0) e = '{4'd2, rn, 32'(imm9), 1'b0};
        else if (f10 == 'h244)                e = '{4'd2,  rn, (w >> 10) & 32'hFFF, 1'b0};
        else if (f10 == 'h344)                e = '{4'd10, rn, (w >> 10) & 32'hFFF, 1'b0};
        else if (f9 == 'h1A5)                 e = '{4'd13, (w >> 5) & 32'hFFFF, 32'd0, 1'b0};
        else if (f8 == 'hB4)                  e = '{4'd7,  rm, 32'd0, 1'b0};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  return (32'h458 << 21) | (r & 32'h1FFFFF);
            1:  return (32'h658 << 21) | (r & 32'h1FFFFF);
            2:  return (32'h450 << 21) | (r & 32'h1FFFFF);
            3:  return (32'h550 << 21) | (r & 32'h1FFFFF);
            4:  return (32'h650 << 21) | (r & 32'h1FFFFF);
            5:  return (32'h7C2 << 21) | (r & 32'h1FFFFF);
            6:  return (32'h7C0 << 21) | (r & 32'h1FFFFF);
            7:  return (32'h244 << 22) | (r & 32'h3FFFFF);
            8:  return (32'h344 << 22) | (r & 32'h3FFFFF);
            9:  return (32'h1A5 << 23) | (r & 32'h7FFFFF);
            10: return (32'hB4 << 24) | (r & 32'hFFFFFF);
            default: return r;
        endcase
    endfunction

    // Scoreboard push on every accept.
    always @(negedge clock) begin
        if (resetN && instrValid && instrReady) exp_q.push_back(model(instr, rnData, rmData));
    end

    // Monitor: compare on every issue.
    always @(negedge clock) begin
        if (resetN && opValid && opReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'(opValid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("opcode", 32'(opcode), 32'(e.op));
                chk("inOne", inOne, e.one);
                chk("inTwo", inTwo, e.two);
                chk("illegal", 32'(illegal), 32'(e.ill));
            end
            chk("issueCount", 32'(issueCount), 32'(exp_count));
            exp_count = exp_count + 16'd1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [31:0] rn, input logic [31:0] rm);
        int t = 0;
        instrValid = 1'b1;
        instr      = w;
        rnData     = rn;
        rmData     = rm;
        @(negedge clock);
        while (!instrReady && t < 200) begin
            t++;
            @(negedge clock);
        end
        if (!instrReady) chk("send_timeout", 32'(instrReady), 32'd1);
        @(posedge clock);
        #1;
        instrValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        opReady = 1'b1;
        while ((exp_q.size() != 0 || opValid) && t < 200) begin
            t++;
            @(posedge clock);
            #1;
        end
        if (exp_q.size() != 0 || opValid) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic took;
        #3;
        chk("rst_opValid", 32'(opValid), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_inOne", inOne, 32'd0);
        chk("rst_inTwo", inTwo, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_issueCount", 32'(issueCount), 32'd0);
        chk("rst_instrReady", 32'(instrReady), 32'd1);
        #9 resetN = 1'b1;
        @(posedge clock);
        #1;

        // Directed decode cases
        opReady = 1'b1;
        send(32'h8B030041, 32'd7, 32'd5);
        chk("add_opValid", 32'(opValid), 32'd1);
        chk("add_opcode", 32'(opcode), 32'h2);
        drain();
        chk("add_count", 32'(issueCount), 32'd1);
        send(32'hF85F8041, 32'h100, 32'd0);
        send(32'h91001441, 32'd3, 32'd9);
        send(32'hB4000000, 32'd1, 32'd0);
        send(32'h00000000, 32'd4, 32'd4);
        drain();
        chk("illegal_count", 32'(issueCount), 32'd5);

        // Backpressure: two entries fill the stage, third is held off
        opReady = 1'b0;
        send(32'h8B030041, 32'd11, 32'd12);
        send(32'hCB030041, 32'd21, 32'd22);
        chk("bp_ready_low", 32'(instrReady), 32'd0);
        instrValid = 1'b1;
        instr      = 32'h8A030041;
        rnData     = 32'd31;
        rmData     = 32'd32;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("bp_ready_held", 32'(instrReady), 32'd0);
        chk("bp_hold_opcode", 32'(opcode), 32'h2);
        chk("bp_hold_inOne", inOne, 32'd11);
        opReady = 1'b1;
        send(32'h8A030041, 32'd31, 32'd32);
        drain();
        chk("bp_ready_after", 32'(instrReady), 32'd1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            took = instrValid && instrReady;
            @(posedge clock);
            #1;
            if (took || !instrValid) begin
                if ($urandom_range(0, 2) != 0) begin
                    instrValid = 1'b1;
                    instr      = rand_instr();
                    rnData     = $urandom;
                    rmData     = $urandom;
                end else begin
                    instrValid = 1'b0;
                end
            end
            opReady = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        took = instrValid && instrReady;
        @(posedge clock);
        #1;
        if (instrValid && !took) send(instr, rnData, rmData);
        instrValid = 1'b0;
        drain();

        // Reset with both entries buffered
        opReady = 1'b0;
        send(rand_instr(), $urandom, $urandom);
        send(rand_instr(), $urandom, $urandom);
        @(negedge clock);
        #2 resetN = 1'b0;
        #1;
        chk("mid_rst_opValid", 32'(opValid), 32'd0);
        chk("mid_rst_issueCount", 32'(issueCount), 32'd0);
        chk("mid_rst_instrReady", 32'(instrReady), 32'd1);
        exp_q.delete();
        exp_count = '0;
        @(negedge clock);
        #2 resetN = 1'b1;
        @(posedge clock);
        #1;

        // Counter wrap: exactly 2^16 issues bring the count back to 0
        opReady = 1'b1;
        for (int i = 0; i < 65536; i++) send(rand_instr(), $urandom, $urandom);
        drain();
        chk("wrap_count", 32'(issueCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
